// File: rtl/lsu_byte_sequencer_if.sv
// rtl/lsu_byte_sequencer_if.sv - pipeline request and byte-memory bundle for lsu_byte_sequencer
// Optional LSU_MISALIGN_TRAP_EN adds the misalign signal.
interface lsu_byte_sequencer_if #(
    parameter int AW = 12
);
    logic          req;
    logic          memread;
    logic          memwrite;
    logic [1:0]    length;
    logic          sign;
    logic [31:0]   address;
    logic [31:0]   wdata;
    logic          ready;
    logic          busy;
    logic          done;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    modport slave (
`ifdef LSU_MISALIGN_TRAP_EN
        output misalign,
`endif
        input  req, memread, memwrite, length, sign, address, wdata, mem_rdata,
        output ready, busy, done, rdata, mem_addr, mem_we, mem_re, mem_wdata
    );

    modport master (
`ifdef LSU_MISALIGN_TRAP_EN
        input  misalign,
`endif
        output req, memread, memwrite, length, sign, address, wdata, mem_rdata,
        input  ready, busy, done, rdata, mem_addr, mem_we, mem_re, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - splits loads/stores into little-endian byte beats on a single-port memory
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete at once with misalign=1.
module lsu_byte_sequencer #(
    parameter int AW = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    lsu_byte_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

    state_e        state_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   asm_q;
    logic [31:0]   asm_d;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    logic [1:0]    length_q;
    logic          sign_q;
    logic [2:0]    cnt_q;
    logic [2:0]    nbeats_q;
    logic          mem_we_q;
    logic          mem_re_q;
    logic          done_q;
    logic [7:0]    mem_wdata_q;
    logic [2:0]    cnt_nx;
    logic [1:0]    cap_idx;
    logic [AW-1:0] addr_nx;
    logic [2:0]    req_beats;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          misalign_q;
    logic          req_misaligned;
`endif

    wire unused_addr_hi = ^bus.address[31:AW];

    always_comb begin
        case (bus.length)
            2'b01:   req_beats = 3'd1;
            2'b10:   req_beats = 3'd2;
            default: req_beats = 3'd4;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = (bus.length == 2'b10) ? bus.address[0]
                          : (bus.length == 2'b01) ? 1'b0
                          : (bus.address[1:0] != 2'b00);
`endif

    assign cnt_nx  = cnt_q + 3'd1;
    // Byte returned this cycle belongs to the beat issued in the previous cycle.
    assign cap_idx = cnt_q[1:0] - 2'd1;
    assign addr_nx = base_q + AW'(cnt_nx);

    always_comb begin
        asm_d = asm_q;
        if (state_q == READ && cnt_q != 3'd0) begin
            asm_d[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
        end
        case (length_q)
            2'b01:   rdata_d = {{24{sign_q & asm_d[7]}}, asm_d[7:0]};
            2'b10:   rdata_d = {{16{sign_q & asm_d[15]}}, asm_d[15:0]};
            default: rdata_d = asm_d;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            length_q    <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            nbeats_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            done_q      <= 1'b0;
            mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.req && (bus.memread || bus.memwrite)) begin
                        base_q   <= bus.address[AW-1:0];
                        wdata_q  <= bus.wdata;
                        length_q <= bus.length;
                        sign_q   <= bus.sign;
                        nbeats_q <= req_beats;
                        cnt_q    <= '0;
                        asm_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (req_misaligned) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else
`endif
                        if (bus.memwrite) begin
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.address[AW-1:0];
                            mem_wdata_q <= bus.wdata[7:0];
                        end else begin
                            state_q    <= READ;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= bus.address[AW-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (cnt_nx == nbeats_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_nx;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_nx;
                        mem_wdata_q <= wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    end
                end
                READ: begin
                    asm_q <= asm_d;
                    if (cnt_q == nbeats_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_nx;
                        if (cnt_nx != nbeats_q) begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= addr_nx;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_wdata = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.misalign  = misalign_q;
`endif
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - randomized self-checking bench for lsu_byte_sequencer
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
`timescale 1ns/1ps
module tb_lsu_byte_sequencer;
    localparam int AW  = 12;
    localparam int MSZ = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lsu_byte_sequencer_if #(.AW(AW)) bus ();

    lsu_byte_sequencer #(.AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [7:0]  mem     [MSZ];
    logic [7:0]  exp_mem [MSZ];
    logic [31:0] exp_rdata;
    int checks   = 0;
    int failures = 0;

    // Registered-read byte memory.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int wrap(input logic [31:0] addr, input int k);
        return (int'(addr[AW-1:0]) + k) % MSZ;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [1:0] len, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n, lat, done_cyc, we_cnt, re_cnt, both_cnt, busy_bad, mis_bad, limit;
        logic trap, active, mis_at_done;
        logic [31:0] rd_at_done, want;
        n      = (len == 2'b01) ? 1 : (len == 2'b10) ? 2 : 4;
        active = rd | wr;
        trap   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (active && ((len == 2'b10 && addr[0]) || (n == 4 && addr[1:0] != 2'b00))) trap = 1'b1;
`endif
        lat   = !active ? 0 : trap ? 1 : wr ? n + 1 : n + 2;
        limit = active ? 20 : 4;
        done_cyc = 0; we_cnt = 0; re_cnt = 0; both_cnt = 0; busy_bad = 0; mis_bad = 0;
        mis_at_done = 1'b0; rd_at_done = bus.rdata;

        check_eq("ready_at_issue", 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.memread = rd; bus.memwrite = wr; bus.length = len;
        bus.sign = sgn; bus.address = addr; bus.wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) bus.req = 1'b0;
            if (bus.mem_we) we_cnt++;
            if (bus.mem_re) re_cnt++;
            if (bus.mem_we && bus.mem_re) both_cnt++;
            if (bus.busy !== active || bus.ready !== !active) busy_bad++;
`ifdef LSU_MISALIGN_TRAP_EN
            if (bus.done) mis_at_done = bus.misalign;
            else if (bus.misalign) mis_bad++;
`endif
            if (bus.done) begin
                done_cyc   = c;
                rd_at_done = bus.rdata;
                break;
            end
        end

        if (!trap && wr) begin
            for (int k = 0; k < n; k++) exp_mem[wrap(addr, k)] = wd[8*k +: 8];
        end else if (!trap && rd) begin
            want = '0;
            for (int k = 0; k < n; k++) want[8*k +: 8] = exp_mem[wrap(addr, k)];
            if (n == 1 && sgn && want[7])  want[31:8]  = '1;
            if (n == 2 && sgn && want[15]) want[31:16] = '1;
            exp_rdata = want;
        end

        check_eq("done_latency", 32'(done_cyc), 32'(lat));
        check_eq("we_beats", 32'(we_cnt), (!trap && wr) ? 32'(n) : 32'd0);
        check_eq("re_beats", 32'(re_cnt), (!trap && rd && !wr) ? 32'(n) : 32'd0);
        check_eq("we_re_overlap", 32'(both_cnt), 32'd0);
        check_eq("busy_ready", 32'(busy_bad), 32'd0);
        check_eq("rdata", rd_at_done, exp_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("misalign_pulse", 32'(mis_at_done), 32'(trap));
        check_eq("misalign_idle", 32'(mis_bad), 32'd0);
`endif
        if (!trap && wr) begin
            for (int k = 0; k < n; k++)
                check_eq("mem_byte", 32'(mem[wrap(addr, k)]), 32'(exp_mem[wrap(addr, k)]));
        end
        if (active) begin
            @(negedge clk);
            check_eq("idle_after_done", {30'd0, bus.ready, bus.done}, 32'h2);
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.memread = 1'b0; bus.memwrite = 1'b0; bus.length = 2'b00;
        bus.sign = 1'b0; bus.address = '0; bus.wdata = '0;
        exp_rdata = '0;
        for (int i = 0; i < MSZ; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_re", 32'(bus.mem_re), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        check_eq("ws_b0", 32'(mem[16'h10]), 32'hEF);
        check_eq("ws_b1", 32'(mem[16'h11]), 32'hBE);
        check_eq("ws_b2", 32'(mem[16'h12]), 32'hAD);
        check_eq("ws_b3", 32'(mem[16'h13]), 32'hDE);

        mem[12'h020] = 8'h80; exp_mem[12'h020] = 8'h80;
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0);
        check_eq("lb_signed", bus.rdata, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0);
        check_eq("lb_unsigned", bus.rdata, 32'h0000_0080);

        mem[12'h030] = 8'h01; exp_mem[12'h030] = 8'h01;
        mem[12'h031] = 8'h80; exp_mem[12'h031] = 8'h80;
        run_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0030, 32'h0);
        check_eq("lh_signed", bus.rdata, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0);
        check_eq("lh_unsigned", bus.rdata, 32'h0000_8001);

        run_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0040, 32'h0000_005A);
        check_eq("both_wr_byte", 32'(mem[12'h040]), 32'h5A);
        check_eq("both_rdata_held", bus.rdata, 32'h0000_8001);

        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0FFF, 32'h1122_3344);
`ifndef LSU_MISALIGN_TRAP_EN
        check_eq("wrap_fff", 32'(mem[12'hFFF]), 32'h44);
        check_eq("wrap_000", 32'(mem[12'h000]), 32'h33);
        check_eq("wrap_001", 32'(mem[12'h001]), 32'h22);
        check_eq("wrap_002", 32'(mem[12'h002]), 32'h11);
`endif

        // Reset during the second beat of a word load.
        bus.req = 1'b1; bus.memread = 1'b1; bus.memwrite = 1'b0; bus.length = 2'b00;
        bus.sign = 1'b0; bus.address = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check_eq("mid_rst_re", 32'(bus.mem_re), 32'd0);
        check_eq("mid_rst_rdata", bus.rdata, 32'd0);
        check_eq("mid_rst_ready", 32'(bus.ready), 32'd1);
        exp_rdata = '0;
        @(negedge clk);
        rstn = 1'b1;
        begin
            int done_seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.done) done_seen++;
            end
            check_eq("mid_rst_no_done", 32'(done_seen), 32'd0);
        end
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("post_rst_load", bus.rdata, 32'hDEAD_BEEF);

        for (int t = 0; t < 200; t++) begin
            int r;
            logic rd, wr;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            rd = (r == 1) || (r >= 6);
            wr = (r == 1) || (r >= 2 && r <= 5);
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a[AW-1:0] = AW'(MSZ - 1 - int'($urandom_range(0, 3)));
            run_op(rd, wr, 2'($urandom), 1'($urandom), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
